twos_complement_sequential_binary_divider: RTL and testbench

Iterative signed (two's complement) divider. It is the inverse operation of the team's 8x8 two's complement multiplier: a 2W-bit product-width dividend divided by a W-bit divisor gives a W-bit quotient and a W-bit remainder. It uses a magnitude restoring shift/subtract datapath with one quotient bit per clock and a start/busy/done handshake. It sits beside the multiplier in the arithmetic test datapath and can undo its products.

---
 rtl/twos_complement_sequential_binary_divider.sv | 171 +++++++++++++++++
 tb/tb_twos_complement_sequential_binary_divider.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/twos_complement_sequential_binary_divider.sv
// Iterative signed divider: 2W-bit dividend / W-bit divisor, one quotient bit per clock.
// Magnitude restoring shift/subtract with sign fix-up in a final registered step.
module twos_complement_sequential_binary_divider #(
    parameter int unsigned W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2*W-1:0]   dividend,
    input  logic [W-1:0]     divisor,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     quotient,
    output logic [W-1:0]     remainder,
    output logic             ovf,
    output logic             dbz
);

    localparam int unsigned CntW = $clog2(2 * W + 1);
    localparam logic [2*W-1:0] NegLim = {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};
    localparam logic [2*W-1:0] PosLim = NegLim - 1'b1;

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [W:0]       r_q, r_d;
    logic [2*W-1:0]   q_q, q_d;
    logic [W-1:0]     dvs_q, dvs_d;
    logic             sd_q, sd_d;
    logic             sv_q, sv_d;
    logic             zdiv_q, zdiv_d;
    logic             done_q, done_d;
    logic [W-1:0]     quot_q, quot_d;
    logic [W-1:0]     rem_q, rem_d;
    logic             ovf_q, ovf_d;
    logic             dbz_q, dbz_d;

    logic [W:0]       r_sh;
    logic [2*W-1:0]   q_sh;
    logic             fits;
    logic             neg;
    logic [2*W-1:0]   q_neg;
    logic [W-1:0]     rem_neg;

    // R is one bit wider than the divisor so the compare stays exact for |divisor| = 2^(W-1).
    assign r_sh    = {r_q[W-1:0], q_q[2*W-1]};
    assign q_sh    = {q_q[2*W-2:0], 1'b0};
    assign fits    = r_sh >= {1'b0, dvs_q};
    assign neg     = sd_q ^ sv_q;
    assign q_neg   = '0 - q_q;
    assign rem_neg = '0 - r_q[W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            sd_q    <= 1'b0;
            sv_q    <= 1'b0;
            zdiv_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            sd_q    <= sd_d;
            sv_q    <= sv_d;
            zdiv_q  <= zdiv_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (divisor == '0) ? StFix : StCalc;
                end
            end
            StCalc: begin
                if (cnt_q == CntW'(1)) begin
                    state_d = StFix;
                end
            end
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        r_d    = r_q;
        q_d    = q_q;
        dvs_d  = dvs_q;
        sd_d   = sd_q;
        sv_d   = sv_q;
        zdiv_d = zdiv_q;
        done_d = 1'b0;
        quot_d = quot_q;
        rem_d  = rem_q;
        ovf_d  = ovf_q;
        dbz_d  = dbz_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sd_d   = dividend[2*W-1];
                    sv_d   = divisor[W-1];
                    dvs_d  = divisor[W-1] ? ('0 - divisor) : divisor;
                    r_d    = '0;
                    cnt_d  = CntW'(2 * W);
                    zdiv_d = (divisor == '0);
                    // Divide-by-zero keeps the raw dividend so its low half can be returned.
                    if (divisor == '0) begin
                        q_d = dividend;
                    end else begin
                        q_d = dividend[2*W-1] ? ('0 - dividend) : dividend;
                    end
                end
            end
            StCalc: begin
                cnt_d = cnt_q - 1'b1;
                if (fits) begin
                    r_d = r_sh - {1'b0, dvs_q};
                    q_d = q_sh | {{(2*W-1){1'b0}}, 1'b1};
                end else begin
                    r_d = r_sh;
                    q_d = q_sh;
                end
            end
            StFix: begin
                done_d = 1'b1;
                if (zdiv_q) begin
                    quot_d = '0;
                    rem_d  = q_q[W-1:0];
                    ovf_d  = 1'b0;
                    dbz_d  = 1'b1;
                end else begin
                    quot_d = neg ? q_neg[W-1:0] : q_q[W-1:0];
                    rem_d  = sd_q ? rem_neg : r_q[W-1:0];
                    ovf_d  = neg ? (q_q > NegLim) : (q_q > PosLim);
                    dbz_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy      = (state_q != StIdle);
        done      = done_q;
        quotient  = quot_q;
        remainder = rem_q;
        ovf       = ovf_q;
        dbz       = dbz_q;
    end

endmodule

// File: tb/tb_twos_complement_sequential_binary_divider.sv
// Directed-vector and sequence bench for the sequential signed divider (W = 8).
module tb_twos_complement_sequential_binary_divider;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [2*W-1:0] dividend = '0;
    logic [W-1:0]   divisor = '0;
    logic           busy, done, ovf, dbz;
    logic [W-1:0]   quotient, remainder;

    int checks = 0;
    int failures = 0;

    twos_complement_sequential_binary_divider #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        o;
        logic        z;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called at #1 after a clock edge while idle; returns at #1 after the accepting edge.
    task automatic launch(input logic [15:0] a, input logic [7:0] b);
        start = 1'b1;
        dividend = a;
        divisor = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic check_result(input string tag, input logic [7:0] q, input logic [7:0] r,
                                input logic o, input logic z);
        check({tag, " done"}, 32'(done), 32'(1));
        check({tag, " quotient"}, 32'(quotient), 32'(q));
        check({tag, " remainder"}, 32'(remainder), 32'(r));
        check({tag, " ovf"}, 32'(ovf), 32'(o));
        check({tag, " dbz"}, 32'(dbz), 32'(z));
    endtask

    initial begin
        int n;
        int bad;
        vecs[0]  = '{16'h0014, 8'h04, 8'h05, 8'h00, 1'b0, 1'b0, 18};
        vecs[1]  = '{16'hFFF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0, 18};
        vecs[2]  = '{16'd1000, 8'hF8, 8'h83, 8'h00, 1'b0, 1'b0, 18};
        vecs[3]  = '{16'hFC00, 8'h08, 8'h80, 8'h00, 1'b0, 1'b0, 18};
        vecs[4]  = '{16'h0400, 8'h08, 8'h80, 8'h00, 1'b1, 1'b0, 18};
        vecs[5]  = '{16'hED37, 8'hEB, 8'hE5, 8'h00, 1'b1, 1'b0, 18};
        vecs[6]  = '{16'h1234, 8'h00, 8'h00, 8'h34, 1'b0, 1'b1, 2};
        vecs[7]  = '{16'h0000, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0, 18};
        vecs[8]  = '{16'h8000, 8'h80, 8'h00, 8'h00, 1'b1, 1'b0, 18};
        vecs[9]  = '{16'd100,  8'h80, 8'h00, 8'h64, 1'b0, 1'b0, 18};
        vecs[10] = '{16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0, 18};
        vecs[11] = '{16'd16130, 8'h7F, 8'h7F, 8'h01, 1'b0, 1'b0, 18};
        vecs[12] = '{16'h8000, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 18};

        #2;
        check("reset outputs", {26'd0, busy, done, ovf, dbz, |quotient, |remainder}, 32'd0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Busy window and single-cycle done on the first test-plan vector.
        launch(16'h0014, 8'h04);
        bad = 0;
        for (int k = 1; k <= 17; k++) begin
            if (!busy || done) bad++;
            @(posedge clk);
            #1;
        end
        check("busy window", 32'(bad), 32'd0);
        check("busy at done", 32'(busy), 32'd0);
        check_result("first", 8'h05, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("done pulse width", 32'(done), 32'd0);
        check("result hold", 32'(quotient), 32'h05);

        for (int i = 0; i < 13; i++) begin
            launch(vecs[i].a, vecs[i].b);
            wait_done(n);
            check($sformatf("vec%0d latency", i), 32'(n), 32'(vecs[i].lat));
            check_result($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].o, vecs[i].z);
            @(posedge clk);
            #1;
        end

        // Start pulse with new operands at edge 5 must be ignored.
        launch(16'd1000, 8'hF8);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        dividend = 16'h1234;
        divisor = 8'h00;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 5;
        while (!done && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ignored start latency", 32'(n), 32'd18);
        check_result("ignored start", 8'h83, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // Start held high: second division accepted in the done cycle with no gap.
        start = 1'b1;
        dividend = 16'hFFF9;
        divisor = 8'h02;
        @(posedge clk);
        #1;
        dividend = 16'd100;
        divisor = 8'h07;
        wait_done(n);
        check("b2b first latency", 32'(n), 32'd18);
        check_result("b2b first", 8'hFD, 8'hFF, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b accepted", 32'(busy), 32'd1);
        wait_done(n);
        check("b2b second latency", 32'(n), 32'd18);
        check_result("b2b second", 8'h0E, 8'h02, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // Asynchronous reset at edge 9 aborts the division.
        launch(16'd1000, 8'hF8);
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("async reset", {26'd0, busy, done, ovf, dbz, |quotient, |remainder}, 32'd0);
        bad = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done || busy) bad++;
        end
        check("no done after reset", 32'(bad), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        launch(16'hFF9C, 8'h07);
        wait_done(n);
        check("post reset latency", 32'(n), 32'd18);
        check_result("post reset", 8'hF2, 8'hFE, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // Random operands against an integer reference model.
        for (int i = 0; i < 24; i++) begin
            logic [15:0] a;
            logic [7:0]  b;
            logic [31:0] mq_bits, mr_bits;
            int sa, sb, mq, mr, iq, ir, isb;
            logic eo;
            a = 16'($urandom);
            b = 8'($urandom);
            if (b == 8'h00) b = 8'h03;
            sa = int'($signed(a));
            sb = int'($signed(b));
            mq = sa / sb;
            mr = sa % sb;
            eo = (mq > 127) || (mq < -128);
            mq_bits = mq;
            mr_bits = mr;
            launch(a, b);
            wait_done(n);
            check_result($sformatf("rand%0d", i), mq_bits[7:0], mr_bits[7:0], eo, 1'b0);
            if (!ovf && done) begin
                iq = int'($signed(quotient));
                ir = int'($signed(remainder));
                isb = int'($signed(divisor));
                check($sformatf("rand%0d invariant", i), 32'(iq * isb + ir), 32'(sa));
            end
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
